// File: rtl/pwm_cfg_pkg.sv
// Shared types and constants for the PWM config AXI-Lite write master.
// State encoding, register map, error codes and BRESP decode helpers.
package pwm_cfg_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_AW,
    S_W,
    S_B,
    S_DONE
  } state_t;

  localparam logic [31:0] REG_CLK_BASE = 32'h0;
  localparam logic [31:0] REG_CLK_COEF = 32'h4;
  localparam logic [31:0] REG_PWM_FREQ = 32'h8;
  localparam logic [31:0] REG_DUTY     = 32'hC;

  localparam logic [1:0] ERR_OK      = 2'b00;
  localparam logic [1:0] ERR_BRESP   = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

  localparam logic [1:0] BRESP_OKAY   = 2'b00;
  localparam logic [1:0] BRESP_EXOKAY = 2'b01;
  localparam logic [1:0] BRESP_SLVERR = 2'b10;
  localparam logic [1:0] BRESP_DECERR = 2'b11;

  function automatic logic [31:0] reg_offset(input logic [1:0] idx);
    logic [31:0] off;
    off = REG_CLK_BASE;
    unique case (idx)
      2'd0: off = REG_CLK_BASE;
      2'd1: off = REG_CLK_COEF;
      2'd2: off = REG_PWM_FREQ;
      2'd3: off = REG_DUTY;
      default: off = REG_CLK_BASE;
    endcase
    return off;
  endfunction

  // OKAY and EXOKAY complete the write; SLVERR/DECERR abort.
  function automatic logic bresp_is_err(input logic [1:0] resp);
    return (resp == BRESP_SLVERR) || (resp == BRESP_DECERR);
  endfunction

endpackage

// File: rtl/axi_lite_wr_single.sv
// Single AXI-Lite write engine: AW, then W, then B, all outputs registered.
// Optional wait-limit abort when PWM_CFG_TIMEOUT_EN is defined.
module axi_lite_wr_single
  import pwm_cfg_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic        axi_lite_aclk,
  input  logic        axi_lite_areset,
  input  logic        start,
  input  logic [31:0] start_addr,
  input  logic [31:0] start_data,
  output logic        xfer_done,
  output logic        xfer_err,
  output logic        xfer_tmo,
  output logic [31:0] axi_lite_awaddr,
  output logic        axi_lite_awvalid,
  input  logic        axi_lite_awready,
  output logic [31:0] axi_lite_wdata,
  output logic [3:0]  axi_lite_wstrb,
  output logic        axi_lite_wvalid,
  input  logic        axi_lite_wready,
  input  logic [1:0]  axi_lite_bresp,
  input  logic        axi_lite_bvalid,
  output logic        axi_lite_bready
);

  state_t      state_q, state_n;
  logic        awvalid_n, wvalid_n, bready_n;
  logic [31:0] awaddr_n, wdata_n;
  logic        aw_hs, w_hs, b_hs;
  logic        tmo_hit;

  assign aw_hs = axi_lite_awvalid && axi_lite_awready;
  assign w_hs  = axi_lite_wvalid && axi_lite_wready;
  assign b_hs  = axi_lite_bready && axi_lite_bvalid;

  assign axi_lite_wstrb = 4'hF;

`ifdef PWM_CFG_TIMEOUT_EN
  logic [31:0] cnt_q;

  // Wait counter restarts on every state entry, counts while pending.
  always_ff @(posedge axi_lite_aclk or posedge axi_lite_areset) begin
    if (axi_lite_areset) begin
      cnt_q <= '0;
    end else if (state_n != state_q || state_q == S_IDLE) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 32'd1;
    end
  end

  assign tmo_hit = (state_q != S_IDLE) &&
                   ((cnt_q + 32'd1) >= TIMEOUT_CYCLES);
`else
  assign tmo_hit = 1'b0;
`endif

  // State and AXI output registers.
  always_ff @(posedge axi_lite_aclk or posedge axi_lite_areset) begin
    if (axi_lite_areset) begin
      state_q          <= S_IDLE;
      axi_lite_awvalid <= 1'b0;
      axi_lite_awaddr  <= '0;
      axi_lite_wvalid  <= 1'b0;
      axi_lite_wdata   <= '0;
      axi_lite_bready  <= 1'b0;
    end else begin
      state_q          <= state_n;
      axi_lite_awvalid <= awvalid_n;
      axi_lite_awaddr  <= awaddr_n;
      axi_lite_wvalid  <= wvalid_n;
      axi_lite_wdata   <= wdata_n;
      axi_lite_bready  <= bready_n;
    end
  end

  // Next state, next outputs and completion strobes.
  always_comb begin
    state_n   = state_q;
    awvalid_n = axi_lite_awvalid;
    awaddr_n  = axi_lite_awaddr;
    wvalid_n  = axi_lite_wvalid;
    wdata_n   = axi_lite_wdata;
    bready_n  = axi_lite_bready;
    xfer_done = 1'b0;
    xfer_err  = 1'b0;
    xfer_tmo  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_n   = S_AW;
          awvalid_n = 1'b1;
          awaddr_n  = start_addr;
          wdata_n   = start_data;
        end
      end
      S_AW: begin
        if (aw_hs) begin
          state_n   = S_W;
          awvalid_n = 1'b0;
          wvalid_n  = 1'b1;
        end else if (tmo_hit) begin
          state_n   = S_IDLE;
          awvalid_n = 1'b0;
          xfer_tmo  = 1'b1;
        end
      end
      S_W: begin
        if (w_hs) begin
          state_n  = S_B;
          wvalid_n = 1'b0;
          bready_n = 1'b1;
        end else if (tmo_hit) begin
          state_n  = S_IDLE;
          wvalid_n = 1'b0;
          xfer_tmo = 1'b1;
        end
      end
      S_B: begin
        if (b_hs) begin
          state_n   = S_IDLE;
          bready_n  = 1'b0;
          xfer_done = 1'b1;
          xfer_err  = bresp_is_err(axi_lite_bresp);
          // Back-to-back: next write launches without an idle cycle.
          if (start) begin
            state_n   = S_AW;
            awvalid_n = 1'b1;
            awaddr_n  = start_addr;
            wdata_n   = start_data;
          end
        end else if (tmo_hit) begin
          state_n  = S_IDLE;
          bready_n = 1'b0;
          xfer_tmo = 1'b1;
        end
      end
      default: begin
        state_n   = S_IDLE;
        awvalid_n = 1'b0;
        wvalid_n  = 1'b0;
        bready_n  = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/axi_lite_pwm_cfg_master.sv
// Programs the four PWM config registers via four AXI-Lite writes.
// Define PWM_CFG_TIMEOUT_EN to enable the per-channel wait-limit abort.
module axi_lite_pwm_cfg_master
  import pwm_cfg_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic        axi_lite_aclk,
  input  logic        axi_lite_areset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [31:0] cmd_clk_freq_base,
  input  logic [31:0] cmd_clk_freq_coef,
  input  logic [31:0] cmd_pwm_freq,
  input  logic [31:0] cmd_duty,
  output logic        busy,
  output logic        done,
  output logic [1:0]  err_code,
  output logic [1:0]  err_idx,
  output logic [31:0] axi_lite_awaddr,
  output logic        axi_lite_awvalid,
  input  logic        axi_lite_awready,
  output logic [31:0] axi_lite_wdata,
  output logic [3:0]  axi_lite_wstrb,
  output logic        axi_lite_wvalid,
  input  logic        axi_lite_wready,
  input  logic [1:0]  axi_lite_bresp,
  input  logic        axi_lite_bvalid,
  output logic        axi_lite_bready
);

  typedef enum logic [1:0] {
    SEQ_IDLE,
    SEQ_RUN,
    SEQ_DONE
  } seq_t;

  seq_t        seq_q, seq_n;
  logic [1:0]  idx_q, idx_n, next_idx;
  logic [1:0]  err_code_n, err_idx_n;
  logic [31:0] word_q [4];
  logic        accept, start;
  logic [31:0] start_addr, start_data;
  logic        xfer_done, xfer_err, xfer_tmo;

  assign accept   = cmd_valid && cmd_ready;
  assign next_idx = accept ? 2'd0 : idx_q + 2'd1;
  assign start    = accept ||
                    (xfer_done && !xfer_err && idx_q != 2'd3);
  assign start_addr = BASE_ADDR + reg_offset(next_idx);
  assign start_data = accept ? cmd_clk_freq_base
                             : word_q[next_idx];

  axi_lite_wr_single #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wr (
    .axi_lite_aclk   (axi_lite_aclk),
    .axi_lite_areset (axi_lite_areset),
    .start           (start),
    .start_addr      (start_addr),
    .start_data      (start_data),
    .xfer_done       (xfer_done),
    .xfer_err        (xfer_err),
    .xfer_tmo        (xfer_tmo),
    .axi_lite_awaddr (axi_lite_awaddr),
    .axi_lite_awvalid(axi_lite_awvalid),
    .axi_lite_awready(axi_lite_awready),
    .axi_lite_wdata  (axi_lite_wdata),
    .axi_lite_wstrb  (axi_lite_wstrb),
    .axi_lite_wvalid (axi_lite_wvalid),
    .axi_lite_wready (axi_lite_wready),
    .axi_lite_bresp  (axi_lite_bresp),
    .axi_lite_bvalid (axi_lite_bvalid),
    .axi_lite_bready (axi_lite_bready)
  );

  // Sequencer state, command latch and registered status outputs.
  always_ff @(posedge axi_lite_aclk or posedge axi_lite_areset) begin
    if (axi_lite_areset) begin
      seq_q     <= SEQ_IDLE;
      idx_q     <= '0;
      for (int i = 0; i < 4; i++) word_q[i] <= '0;
      cmd_ready <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      err_code  <= ERR_OK;
      err_idx   <= '0;
    end else begin
      seq_q     <= seq_n;
      idx_q     <= idx_n;
      if (accept) begin
        word_q[0] <= cmd_clk_freq_base;
        word_q[1] <= cmd_clk_freq_coef;
        word_q[2] <= cmd_pwm_freq;
        word_q[3] <= cmd_duty;
      end
      cmd_ready <= (seq_n == SEQ_IDLE);
      busy      <= (seq_n != SEQ_IDLE);
      done      <= (seq_n == SEQ_DONE);
      err_code  <= err_code_n;
      err_idx   <= err_idx_n;
    end
  end

  // Sequencing across the four writes and error capture.
  always_comb begin
    seq_n      = seq_q;
    idx_n      = idx_q;
    err_code_n = err_code;
    err_idx_n  = err_idx;
    unique case (seq_q)
      SEQ_IDLE: begin
        if (accept) begin
          seq_n      = SEQ_RUN;
          idx_n      = 2'd0;
          err_code_n = ERR_OK;
          err_idx_n  = 2'd0;
        end
      end
      SEQ_RUN: begin
        if (xfer_tmo) begin
          seq_n      = SEQ_DONE;
          err_code_n = ERR_TIMEOUT;
          err_idx_n  = idx_q;
        end else if (xfer_done) begin
          if (xfer_err) begin
            seq_n      = SEQ_DONE;
            err_code_n = ERR_BRESP;
            err_idx_n  = idx_q;
          end else if (idx_q == 2'd3) begin
            seq_n      = SEQ_DONE;
            err_code_n = ERR_OK;
            err_idx_n  = 2'd0;
          end else begin
            idx_n = idx_q + 2'd1;
          end
        end
      end
      SEQ_DONE: begin
        seq_n = SEQ_IDLE;
      end
      default: begin
        seq_n = SEQ_IDLE;
      end
    endcase
  end

endmodule
